// File: rtl/btn_conditioner.sv
// N-channel push-button conditioner: sync, tick-sampled debounce, press/release pulses, entropy seed.
// Define BTN_REPEAT_EN to add hold-to-repeat press pulses.
module btn_conditioner #(
  parameter int NBTN         = 5,
  parameter int DIV_W        = 17,
  parameter int STABLE       = 3,
  parameter int SEED_W       = 2,
  parameter int REPEAT_DELAY = 200,
  parameter int REPEAT_RATE  = 50
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NBTN-1:0]   btn_raw,
  output logic [NBTN-1:0]   btn_level,
  output logic [NBTN-1:0]   btn_press,
  output logic [NBTN-1:0]   btn_release,
  output logic              any_press,
  output logic              sample_tick,
  output logic [SEED_W-1:0] seed
);

  localparam int HW = STABLE - 1;

  logic [DIV_W-1:0] div_cnt;
  logic [NBTN-1:0]  sync_a;
  logic [NBTN-1:0]  sync_b;
  logic [HW-1:0]    hist [NBTN];
  logic [NBTN-1:0]  rise;
  logic [NBTN-1:0]  fall;
  logic [NBTN-1:0]  quiet;
  logic [NBTN-1:0]  rep;

  // Window is the live synchronised sample plus the previous STABLE-1 tick samples.
  always_comb begin
    logic [STABLE-1:0] win;
    win   = '0;
    rise  = '0;
    fall  = '0;
    quiet = '0;
    for (int i = 0; i < NBTN; i++) begin
      win      = {sync_b[i], hist[i]};
      quiet[i] = ~|win;
      rise[i]  = sample_tick & (&win) & ~btn_level[i];
      fall[i]  = sample_tick & quiet[i] & btn_level[i];
    end
  end

`ifdef BTN_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = $clog2(RMAX + 1);
  localparam logic [RW-1:0] DELAY_LIM = RW'(REPEAT_DELAY);
  localparam logic [RW-1:0] RATE_LIM  = RW'(REPEAT_RATE);

  logic [RW-1:0]   rcnt [NBTN];
  logic [NBTN-1:0] rphase;

  always_comb begin
    rep = '0;
    for (int i = 0; i < NBTN; i++) begin
      rep[i] = sample_tick & btn_level[i] & ~quiet[i] &
               ((rcnt[i] + RW'(1)) == (rphase[i] ? RATE_LIM : DELAY_LIM));
    end
  end

  // rphase selects the first (long) delay versus the steady repeat rate.
  always_ff @(posedge clk) begin
    if (rst) begin
      rphase <= '0;
      for (int i = 0; i < NBTN; i++) rcnt[i] <= '0;
    end else begin
      for (int i = 0; i < NBTN; i++) begin
        if (!btn_level[i] || fall[i]) begin
          rcnt[i]   <= '0;
          rphase[i] <= 1'b0;
        end else if (sample_tick) begin
          if (rep[i]) begin
            rcnt[i]   <= '0;
            rphase[i] <= 1'b1;
          end else begin
            rcnt[i] <= rcnt[i] + RW'(1);
          end
        end
      end
    end
  end
`else
  assign rep = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt     <= '0;
      sample_tick <= 1'b0;
      sync_a      <= '0;
      sync_b      <= '0;
      btn_level   <= '0;
      btn_press   <= '0;
      btn_release <= '0;
      any_press   <= 1'b0;
      seed        <= '0;
      for (int i = 0; i < NBTN; i++) hist[i] <= '0;
    end else begin
      div_cnt     <= div_cnt + DIV_W'(1);
      sample_tick <= (div_cnt == '1);
      sync_a      <= btn_raw;
      sync_b      <= sync_a;
      btn_level   <= (btn_level | rise) & ~fall;
      btn_press   <= rise | rep;
      btn_release <= fall;
      any_press   <= |(rise | rep);
      if (|sync_b) seed <= seed + SEED_W'(1);
      if (sample_tick) begin
        for (int i = 0; i < NBTN; i++) hist[i] <= (hist[i] << 1) | HW'(sync_b[i]);
      end
    end
  end

endmodule
